serial_arith_unit: RTL and testbench

//   Parametrised bit-serial add/subtract/compare/accumulate unit with a start/busy/done handshake.

---
 rtl/serial_arith_unit.sv | 127 ++++++++++++
 tb/tb_serial_arith_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/serial_arith_unit.sv
// serial_arith_unit: bit-serial add/sub/compare/accumulate unit, LSB first; SERIAL_OVERFLOW_EN enables the signed overflow flag
module serial_arith_unit #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             equal,
  output logic             not_equal,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [1:0] M_ADD = 2'd0, M_SUB = 2'd1, M_CMP = 2'd2, M_ACC = 2'd3;
  logic [1:0]       state_q, state_d, mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, p_q, p_d, acc_q, acc_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, eq_q, eq_d, carry_q, carry_d, equal_q, equal_d, ne_q, ne_d, ov_q, ov_d;
  logic             s, cn, eq_n, inv;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign equal     = equal_q;
  assign not_equal = ne_q;
  assign overflow  = ov_q;
  // one full-adder slice per cycle; operands shift right, sum shifts in at the MSB
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    p_d      = p_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    eq_d     = eq_q;
    result_d = result_q;
    carry_d  = carry_q;
    equal_d  = equal_q;
    ne_d     = ne_q;
    ov_d     = ov_q;
    s        = a_q[0] ^ y_q[0] ^ c_q;
    cn       = (a_q[0] & y_q[0]) | ((a_q[0] ^ y_q[0]) & c_q);
    eq_n     = eq_q & ~(a_q[0] ^ b_q[0]);
    inv      = mode == M_SUB || mode == M_CMP;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        mode_d  = mode;
        a_d     = a;
        b_d     = b;
        y_d     = mode == M_ACC ? acc_q : inv ? ~b : b;
        c_d     = inv;
        cnt_d   = '0;
        eq_d    = 1'b1;
      end
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      y_d   = y_q >> 1;
      p_d   = {s, p_q[WIDTH-1:1]};
      c_d   = cn;
      eq_d  = eq_n;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d  = DONE;
        result_d = mode_q == M_CMP ? {{(WIDTH-1){1'b0}}, eq_n} : p_d;
        carry_d  = cn;
        equal_d  = eq_n;
        ne_d     = ~eq_n;
        acc_d    = mode_q == M_ACC ? p_d : acc_q;
`ifdef SERIAL_OVERFLOW_EN
        ov_d     = mode_q == M_CMP ? 1'b0 : c_q ^ cn;
`else
        ov_d     = 1'b0;
`endif
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state registers with synchronous reset; reset mid-run abandons the operation
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      p_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      eq_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      equal_q  <= 1'b0;
      ne_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      eq_q     <= eq_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      equal_q  <= equal_d;
      ne_q     <= ne_d;
      ov_q     <= ov_d;
    end
  end
endmodule

// File: tb/tb_serial_arith_unit.sv
// tb_serial_arith_unit: randomized bench for serial_arith_unit against an arithmetic reference model
module tb_serial_arith_unit;
  localparam int W = 5;
  localparam int M = 1 << W;
  logic clock = 0, reset, start;
  logic [1:0] mode;
  logic [W-1:0] a, b, result;
  logic busy, done, carry_out, equal, not_equal, overflow;
  int total = 0, bad = 0;
  int acc_m = 0;
  int exp_res, exp_c, exp_ov;
  serial_arith_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .equal(equal), .not_equal(not_equal), .overflow(overflow)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sgn(input int x);
    return x >= M / 2 ? x - M : x;
  endfunction
  task automatic model(input int m, input int x, input int y);
    int full, sv;
    full = 0;
    sv = 0;
    if (m == 0) begin full = x + y; sv = sgn(x) + sgn(y); end
    if (m == 1 || m == 2) begin full = x + (M - 1 - y) + 1; sv = sgn(x) - sgn(y); end
    if (m == 3) begin full = acc_m + x; sv = sgn(acc_m) + sgn(x); end
    exp_c = full / M;
    exp_res = m == 2 ? int'(x == y) : full % M;
`ifdef SERIAL_OVERFLOW_EN
    exp_ov = m != 2 && (sv > M / 2 - 1 || sv < -(M / 2));
`else
    exp_ov = 0;
`endif
    if (m == 3) acc_m = exp_res;
  endtask
  task automatic do_op(input int m, input int x, input int y, input bit poke);
    int n;
    @(negedge clock);
    start = 1;
    mode = 2'(m);
    a = W'(x);
    b = W'(y);
    model(m, x, y);
    @(negedge clock);
    start = 0;
    a = W'($urandom);
    b = W'($urandom);
    mode = 2'($urandom);
    n = 1;
    while (!done && n < 20) begin
      start = poke && n == 2;
      @(negedge clock);
      n++;
    end
    start = 0;
    chk("latency", n, W + 1);
    chk("busy_done", int'(busy), 1);
    chk("result", int'(result), exp_res);
    chk("carry", int'(carry_out), exp_c);
    chk("equal", int'(equal), int'(x == y));
    chk("not_equal", int'(not_equal), int'(x != y));
    chk("overflow", int'(overflow), exp_ov);
    @(negedge clock);
    chk("done_pulse", int'(done), 0);
    chk("held", int'(result), exp_res);
    if (poke) begin
      n = 0;
      for (int i = 0; i < W + 3; i++) begin
        n += int'(done);
        @(negedge clock);
      end
      chk("no_extra_done", n, 0);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_out"}, int'({result, carry_out, equal, not_equal, overflow}), 0);
  endtask
  initial begin
    int n;
    reset = 1;
    start = 0;
    mode = 0;
    a = 0;
    b = 0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 0;
    do_op(0, 5'b01100, 5'b00110, 0);
    do_op(1, 5'b01100, 5'b00110, 0);
    do_op(2, 5'b01100, 5'b01100, 0);
    do_op(2, 5'b01100, 5'b01010, 0);
    @(negedge clock);
    reset = 1;
    acc_m = 0;
    @(negedge clock);
    reset = 0;
    do_op(3, 31, 0, 0);
    chk("acc1", int'(result), 31);
    do_op(3, 31, 0, 0);
    chk("acc2", int'({carry_out, result}), 62);
    do_op(3, 31, 0, 0);
    chk("acc3", int'({carry_out, result}), 61);
    do_op(0, 7, 9, 1);
    @(negedge clock);
    start = 1;
    mode = 0;
    a = 5'd3;
    b = 5'd4;
    @(negedge clock);
    start = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    acc_m = 0;
    chk_zero("abort");
    n = 0;
    for (int i = 0; i < W + 3; i++) begin
      n += int'(done);
      @(negedge clock);
    end
    chk("abort_no_done", n, 0);
    do_op(0, 1, 1, 0);
    chk("post_abort", int'(result), 2);
    for (int i = 0; i < 60; i++)
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, M - 1)), $urandom_range(0, 3) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
